// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the registered 16-bit ALU: FIFO-buffered issue, result capture, valid/ready output.
// Optional divide-by-zero trap enabled by defining ALU_SEQ_DIV_ZERO_TRAP_EN.
module alu_cmd_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_A,
  input  logic [WIDTH-1:0] cmd_B,
  input  logic [3:0]       cmd_FUN,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [3:0]       ALU_FUN,
  input  logic [WIDTH-1:0] ALU_OUT_in,
  input  logic [4:0]       ALU_FLAGS_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [4:0]       res_flags,
  output logic             res_err,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       fun;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, HOLD
`ifdef ALU_SEQ_DIV_ZERO_TRAP_EN
    , TRAP
`endif
  } state_t;

  cmd_t             fifo_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_b_q, res_data_q;
  logic [3:0]       alu_fun_q;
  logic [4:0]       res_flags_q;
  logic             res_valid_q;
  logic             push, pop, load_op, capture, release_res, trap_fire, fifo_empty;
  cmd_t             head;

  assign cmd_ready  = (count_q != CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = cmd_valid && cmd_ready;
  assign head       = fifo_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    load_op     = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    trap_fire   = 1'b0;
    unique case (state_q)
      IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        load_op = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD: if (res_ready) begin
        release_res = 1'b1;
        state_d     = IDLE;
        if (!fifo_empty) begin
          pop     = 1'b1;
          load_op = 1'b1;
          state_d = ISSUE;
        end
      end
`ifdef ALU_SEQ_DIV_ZERO_TRAP_EN
      TRAP: begin
        trap_fire = 1'b1;
        state_d   = HOLD;
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef ALU_SEQ_DIV_ZERO_TRAP_EN
    // Divide by zero never reaches the ALU; operand registers keep their old value.
    if (pop && head.fun == 4'b0011 && head.b == '0) begin
      load_op = 1'b0;
      state_d = TRAP;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= {cmd_A, cmd_B, cmd_FUN};
        wr_ptr_q         <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
      if (load_op) begin
        alu_a_q   <= head.a;
        alu_b_q   <= head.b;
        alu_fun_q <= head.fun;
      end
      if (capture) begin
        res_data_q  <= ALU_OUT_in;
        res_flags_q <= ALU_FLAGS_in;
        res_valid_q <= 1'b1;
      end else if (trap_fire) begin
        res_data_q  <= '0;
        res_flags_q <= 5'b01000;
        res_valid_q <= 1'b1;
      end else if (release_res) begin
        res_valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_DIV_ZERO_TRAP_EN
  logic res_err_q;
  always_ff @(posedge CLK) begin
    if (RST)            res_err_q <= 1'b0;
    else if (capture)   res_err_q <= 1'b0;
    else if (trap_fire) res_err_q <= 1'b1;
  end
  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_FUN   = alu_fun_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_flags = res_flags_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a stand-in registered ALU model.
module tb_alu_cmd_sequencer;
  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST;
  logic         cmd_valid, cmd_ready;
  logic [W-1:0] cmd_A, cmd_B;
  logic [3:0]   cmd_FUN;
  logic [W-1:0] ALU_A, ALU_B;
  logic [3:0]   ALU_FUN;
  logic [W-1:0] ALU_OUT_in;
  logic [4:0]   ALU_FLAGS_in;
  logic         res_valid, res_ready;
  logic [W-1:0] res_data;
  logic [4:0]   res_flags;
  logic         res_err, busy;

  always #5 CLK = ~CLK;

  alu_cmd_sequencer #(.WIDTH(W), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_FUN(cmd_FUN),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .ALU_OUT_in(ALU_OUT_in), .ALU_FLAGS_in(ALU_FLAGS_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags),
    .res_err(res_err), .busy(busy)
  );

  // Registered ALU stand-in; flags {Carry,Arith,Logic,CMP,Shift}. Noise perturbs its outputs.
  logic [W-1:0] alu_d, alu_q;
  logic [4:0]   flg_d, flg_q;
  logic [W:0]   sum;
  logic [W-1:0] noise_d = '0;
  logic [4:0]   noise_f = '0;

  always_comb begin
    alu_d = '0;
    flg_d = '0;
    sum   = {1'b0, ALU_A} + {1'b0, ALU_B};
    case (ALU_FUN)
      4'h0: begin alu_d = sum[W-1:0]; flg_d = {sum[W], 4'b1000}; end
      4'h1: begin alu_d = ALU_A - ALU_B; flg_d = 5'b01000; end
      4'h2: begin alu_d = W'(ALU_A * ALU_B); flg_d = 5'b01000; end
      4'h3: begin alu_d = (ALU_B == '0) ? '0 : ALU_A / ALU_B; flg_d = 5'b01000; end
      4'h4: begin alu_d = ALU_A & ALU_B; flg_d = 5'b00100; end
      4'h5: begin alu_d = ALU_A | ALU_B; flg_d = 5'b00100; end
      4'h6: begin alu_d = ~(ALU_A & ALU_B); flg_d = 5'b00100; end
      4'h7: begin alu_d = ~(ALU_A | ALU_B); flg_d = 5'b00100; end
      4'h8: begin alu_d = ALU_A ^ ALU_B; flg_d = 5'b00100; end
      4'h9: begin alu_d = ~(ALU_A ^ ALU_B); flg_d = 5'b00100; end
      4'hA: begin alu_d = W'(ALU_A == ALU_B); flg_d = 5'b00010; end
      4'hB: begin alu_d = W'(ALU_A > ALU_B); flg_d = 5'b00010; end
      4'hC: begin alu_d = W'(ALU_A < ALU_B); flg_d = 5'b00010; end
      4'hD: begin alu_d = ALU_A >> ALU_B[3:0]; flg_d = 5'b00001; end
      4'hE: begin alu_d = ALU_A << ALU_B[3:0]; flg_d = 5'b00001; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    alu_q <= alu_d;
    flg_q <= flg_d;
  end

  assign ALU_OUT_in   = alu_q ^ noise_d;
  assign ALU_FLAGS_in = flg_q ^ noise_f;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Push one command into an idle sequencer, wait for its result, check it, then drain.
  task automatic run_one(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] fun, input logic [W-1:0] ed, input logic [4:0] ef,
                         input int lat, input logic eerr);
    int n;
    chk({nm, " ready"}, 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_A = a; cmd_B = b; cmd_FUN = fun; res_ready = 1'b0;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 10) begin step(); n++; end
    chk({nm, " latency"}, 32'(n), 32'(lat));
    chk({nm, " data"}, 32'(res_data), 32'(ed));
    chk({nm, " flags"}, 32'(res_flags), 32'(ef));
    chk({nm, " err"}, 32'(res_err), 32'(eerr));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({nm, " valid_clr"}, 32'(res_valid), 0);
    chk({nm, " busy_clr"}, 32'(busy), 0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   fun;
    logic [W-1:0] exp_d;
    logic [4:0]   exp_f;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [W-1:0] ea[5];
    int got, n, extra;

    vt[0] = '{16'd6,     16'd7,     4'h0, 16'd13,    5'b01000};
    vt[1] = '{16'hFFFF,  16'd1,     4'h0, 16'd0,     5'b11000};
    vt[2] = '{16'd15,    16'd4,     4'h1, 16'd11,    5'b01000};
    vt[3] = '{16'd4,     16'd3,     4'h2, 16'd12,    5'b01000};
    vt[4] = '{16'd9,     16'd3,     4'h3, 16'd3,     5'b01000};
    vt[5] = '{16'hF0F0,  16'h0FF0,  4'h4, 16'h00F0,  5'b00100};
    vt[6] = '{16'h00FF,  16'h0F0F,  4'h8, 16'h0FF0,  5'b00100};
    vt[7] = '{16'd10,    16'd15,    4'hB, 16'd0,     5'b00010};
    vt[8] = '{16'h0001,  16'd4,     4'hE, 16'h0010,  5'b00001};
    vt[9] = '{16'h8000,  16'd1,     4'hD, 16'h4000,  5'b00001};

    // Reset with a command presented: it must be dropped.
    RST = 1'b1; cmd_valid = 1'b1; cmd_A = 16'd99; cmd_B = 16'd1; cmd_FUN = 4'h0; res_ready = 1'b0;
    step(); step();
    RST = 1'b0; cmd_valid = 1'b0;
    chk("rst res_valid", 32'(res_valid), 0);
    chk("rst cmd_ready", 32'(cmd_ready), 1);
    chk("rst busy", 32'(busy), 0);
    chk("rst alu_a", 32'(ALU_A), 0);
    chk("rst alu_fun", 32'(ALU_FUN), 0);
    chk("rst res_data", 32'(res_data), 0);
    chk("rst res_flags", 32'(res_flags), 0);
    chk("rst res_err", 32'(res_err), 0);
    extra = 0;
    repeat (6) begin if (res_valid || busy) extra++; step(); end
    chk("rst drop", 32'(extra), 0);

    // Single commands through an idle sequencer.
    for (int i = 0; i < 10; i++)
      run_one($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].fun, vt[i].exp_d, vt[i].exp_f, 3, 1'b0);

    // Back-to-back fill: one in flight plus four queued, then drain in order.
    ea[0] = 16'd2; ea[1] = 16'd11; ea[2] = 16'd12; ea[3] = 16'd3; ea[4] = 16'd0;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2 ready%0d", i), 32'(cmd_ready), 1);
      cmd_valid = 1'b1;
      case (i)
        0: begin cmd_A = 16'd1;  cmd_B = 16'd1;  cmd_FUN = 4'h0; end
        1: begin cmd_A = 16'd15; cmd_B = 16'd4;  cmd_FUN = 4'h1; end
        2: begin cmd_A = 16'd4;  cmd_B = 16'd3;  cmd_FUN = 4'h2; end
        3: begin cmd_A = 16'd9;  cmd_B = 16'd3;  cmd_FUN = 4'h3; end
        default: begin cmd_A = 16'd10; cmd_B = 16'd15; cmd_FUN = 4'hB; end
      endcase
      step();
    end
    chk("t2 full", 32'(cmd_ready), 0);
    cmd_A = 16'd100; cmd_B = 16'd100; cmd_FUN = 4'h0;
    step(); step();
    chk("t2 still full", 32'(cmd_ready), 0);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    got = 0; n = 0;
    while (got < 5 && n < 40) begin
      if (res_valid) begin
        chk($sformatf("t2 res%0d", got), 32'(res_data), 32'(ea[got]));
        got++;
      end
      step(); n++;
    end
    chk("t2 count", 32'(got), 5);
    extra = 0;
    repeat (10) begin if (res_valid) extra++; step(); end
    chk("t2 no extra", 32'(extra), 0);
    res_ready = 1'b0;
    chk("t2 idle", 32'(busy), 0);

    // Simultaneous push and pop while holding with two queued.
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_A = 16'(2 * i + 1); cmd_B = 16'(2 * i + 2); cmd_FUN = 4'h0;
      step();
    end
    cmd_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 10) begin step(); n++; end
    chk("t3 first", 32'(res_data), 3);
    cmd_valid = 1'b1; cmd_A = 16'd7; cmd_B = 16'd8; cmd_FUN = 4'h0; res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t3 ready%0d", i), 32'(cmd_ready), 1);
      cmd_A = 16'(20 + 10 * i); cmd_B = 16'd1;
      step();
    end
    cmd_valid = 1'b0;
    chk("t3 full", 32'(cmd_ready), 0);
    ea[0] = 16'd7; ea[1] = 16'd11; ea[2] = 16'd15; ea[3] = 16'd21; ea[4] = 16'd31;
    res_ready = 1'b1;
    got = 0; n = 0;
    while (got < 5 && n < 40) begin
      if (res_valid) begin
        chk($sformatf("t3 res%0d", got), 32'(res_data), 32'(ea[got]));
        got++;
      end
      step(); n++;
    end
    chk("t3 count", 32'(got), 5);
    res_ready = 1'b0;
    step();

    // Divide by zero.
    run_one("t4pre", 16'h8000, 16'd1, 4'hD, 16'h4000, 5'b00001, 3, 1'b0);
`ifdef ALU_SEQ_DIV_ZERO_TRAP_EN
    run_one("t4trap", 16'd14, 16'd0, 4'h3, 16'd0, 5'b01000, 2, 1'b1);
    chk("t4 fun kept", 32'(ALU_FUN), 32'hD);
    chk("t4 a kept", 32'(ALU_A), 32'h8000);
`else
    run_one("t4div", 16'd14, 16'd0, 4'h3, 16'd0, 5'b01000, 3, 1'b0);
    chk("t4 fun issued", 32'(ALU_FUN), 3);
    chk("t4 a issued", 32'(ALU_A), 14);
`endif

    // Reset during WAIT with three queued.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_A = 16'(40 + i); cmd_B = 16'd1; cmd_FUN = 4'h0;
      step();
    end
    cmd_A = 16'd50; res_ready = 1'b1;
    step();
    res_ready = 1'b0; cmd_valid = 1'b0;
    step();
    RST = 1'b1; cmd_valid = 1'b1; cmd_A = 16'd60;
    step();
    RST = 1'b0; cmd_valid = 1'b0;
    chk("t5 res_valid", 32'(res_valid), 0);
    chk("t5 cmd_ready", 32'(cmd_ready), 1);
    chk("t5 busy", 32'(busy), 0);
    chk("t5 alu_a", 32'(ALU_A), 0);
    extra = 0;
    repeat (6) begin if (res_valid || busy) extra++; step(); end
    chk("t5 no stale", 32'(extra), 0);
    run_one("t5new", 16'd2, 16'd3, 4'h0, 16'd5, 5'b01000, 3, 1'b0);

    // Frozen result while downstream stalls and the ALU output moves.
    cmd_valid = 1'b1; cmd_A = 16'h1234; cmd_B = 16'h00FF; cmd_FUN = 4'h8;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 10) begin step(); n++; end
    chk("t6 captured", 32'(res_data), 32'h12CB);
    for (int i = 0; i < 10; i++) begin
      noise_d = W'($urandom) | 16'h0001;
      noise_f = 5'($urandom) | 5'b00001;
      step();
      chk($sformatf("t6 data%0d", i), 32'(res_data), 32'h12CB);
      chk($sformatf("t6 flags%0d", i), 32'(res_flags), 32'b00100);
      chk($sformatf("t6 valid%0d", i), 32'(res_valid), 1);
    end
    noise_d = '0; noise_f = '0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t6 release", 32'(res_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream command stage for the 16-bit registered ALU. Accepts operation commands (A, B, function code) over a valid/ready handshake and buffers them in a small FIFO. Issues one command at a time to the ALU, holding operands stable across the ALU's one-cycle register latency. Captures ALU_OUT and the five flags, then presents them downstream over a second valid/ready handshake.

Parameters:
WIDTH, 16, operand/result width; must match the ALU data width
DEPTH, 4, command FIFO entries; power of two, minimum 2

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept; equals (count != DEPTH)
cmd_A  input  WIDTH  operand A
cmd_B  input  WIDTH  operand B
cmd_FUN  input  4  ALU function code (0000 ADD … 1110 SHL)
ALU_A  output  WIDTH  operand A to ALU
ALU_B  output  WIDTH  operand B to ALU
ALU_FUN  output  4  function to ALU
ALU_OUT_in  input  WIDTH  registered ALU result
ALU_FLAGS_in  input  5  {Carry,Arith,Logic,CMP,Shift} from ALU
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
res_data  output  WIDTH  captured result
res_flags  output  5  captured flags, same order as ALU_FLAGS_in
res_err  output  1  error marker (see Optional Feature)
busy  output  1  high when state != IDLE or FIFO non-empty

Behaviour:
- Reset (RST high at an edge):
  - FIFO pointers and count cleared; state set to IDLE.
  - ALU_A, ALU_B, ALU_FUN, res_data, res_flags, res_err, res_valid all 0.
  - cmd_ready is 1 after the reset edge.
  - Any command presented while RST is high is dropped.
  - Reset mid-operation discards the in-flight command and all queued commands. A later ALU_OUT_in value from the discarded command is never captured.
- Push: occurs at an edge when cmd_valid && cmd_ready. Entry stored as {cmd_A, cmd_B, cmd_FUN}.
  - Push and pop in the same cycle are allowed. Count is unchanged; no data loss.
- States:
  - IDLE: if FIFO non-empty, pop the head into the ALU_A/ALU_B/ALU_FUN registers; go to ISSUE. Otherwise stay.
  - ISSUE (1 cycle): operands stable. The ALU registers them at the closing edge. Go to WAIT.
  - WAIT (1 cycle): operands held stable. At the closing edge, capture ALU_OUT_in into res_data and ALU_FLAGS_in into res_flags; set res_valid=1; go to HOLD.
  - HOLD: res_valid=1; result outputs frozen.
    - res_ready=1 at an edge, FIFO non-empty: clear res_valid, pop the next head into the operand registers, go to ISSUE.
    - res_ready=1 at an edge, FIFO empty: clear res_valid, go to IDLE.
    - res_ready=0: stay.
- ALU_A, ALU_B and ALU_FUN change only at a pop and keep their last value otherwise.
- Latency: a command accepted at edge 0 into an empty, idle sequencer gives res_valid=1 after edge 3.
- Throughput with res_ready tied high: one result every 3 cycles.
- FIFO full: cmd_ready=0 and cmd_valid is ignored. Pointers wrap modulo DEPTH.
- Results are delivered strictly in acceptance order. No command is dropped except on reset.

Optional Feature:
Macro ALU_SEQ_DIV_ZERO_TRAP_EN.
- Defined: when the popped entry has cmd_FUN=4'b0011 and cmd_B=0, the ALU is not issued.
  - The state goes IDLE/HOLD -> TRAP (1 cycle) -> HOLD with res_data=0, res_flags=5'b01000, res_err=1.
  - Latency is 2 edges after the pop decision instead of 3.
  - ALU_A/ALU_B/ALU_FUN keep their previous values for the trapped command.
- Undefined: divide-by-zero is issued to the ALU like any other command. res_err is tied 0. The TRAP state does not exist.

Test Plan:
1. Reset, then push A=6, B=7, FUN=0000 at edge 0, res_ready=1 -> res_valid after edge 3; res_data=13; res_flags Arith=1; busy returns 0 after the handshake.
2. res_ready=0, push 5 commands back-to-back (ADD 1+1, SUB 15-4, MUL 4*3, DIV 9/3, CMPG 10,15) -> cmd_ready drops after the 5th accepted command (1 in flight + 4 queued). Then raise res_ready -> results 2, 11, 12, 3, 0 in order, no loss.
3. Simultaneous push/pop: while HOLD with 2 queued, assert cmd_valid and res_ready in the same cycle -> queue count stays 2; next result is the older queued command.
4. DIV A=14, B=0: with ALU_SEQ_DIV_ZERO_TRAP_EN -> res_data=0, res_err=1, ALU_FUN unchanged. Without the macro -> ALU issued with FUN=0011, res_err=0, res_data equals ALU_OUT_in (0).
5. Assert RST during WAIT with 3 queued -> after the reset edge res_valid=0, cmd_ready=1, busy=0. The next result seen is from a command pushed after reset.
6. res_ready held 0 for 10 cycles in HOLD, ALU_OUT_in changing -> res_data and res_flags remain frozen at the captured values.
